// File: rtl/neo_pkg.sv
// Shared types for the NeoPixel pattern generator: animation modes, FSM states, channel ids.
package neo_pkg;

  typedef enum logic [1:0] {
    SOLID     = 2'b00,
    CHASE     = 2'b01,
    ALTERNATE = 2'b10,
    OFF       = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND_REQ,
    SEND_WAIT
  } state_t;

  localparam logic [1:0] CH_G = 2'd0;
  localparam logic [1:0] CH_R = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

endpackage

// File: rtl/neo_counter.sv
// Modulo-MAX up counter with synchronous clear (clear wins over inc); 1-cycle update, no backpressure.
module neo_counter #(
  parameter int W   = 8,
  parameter int MAX = 256
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == W'(MAX - 1)) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/neo_pattern_lut.sv
// Combinational colour lookup: level for pixel p, channel c at animation phase ph; zero latency.
module neo_pattern_lut
  import neo_pkg::*;
#(
  parameter int IDX_W   = 3,
  parameter int LEVEL_W = 8
) (
  input  mode_t              mode,
  input  logic [IDX_W-1:0]   p,
  input  logic [1:0]         c,
  input  logic [IDX_W-1:0]   ph,
  input  logic [LEVEL_W-1:0] level_hi,
  input  logic [LEVEL_W-1:0] level_lo,
  output logic [LEVEL_W-1:0] level
);

  logic       sum_odd;
  logic [1:0] ph_mod3;

  // Only the parity of the widened p+ph sum matters.
  assign sum_odd = 1'(({1'b0, p} + {1'b0, ph}));
  assign ph_mod3 = 2'(32'(ph) % 32'd3);

  always_comb begin
    level = '0;
    case (mode)
      SOLID: begin
        if (c == ph_mod3) level = level_hi;
      end
      CHASE: begin
        if (p == ph)         level = level_hi;
        else if (c == CH_G)  level = level_lo;
      end
      ALTERNATE: begin
        if (!sum_odd && (c == CH_R))     level = level_hi;
        else if (sum_odd && (c == CH_B)) level = level_lo;
      end
      OFF:     level = '0;
      default: level = '0;
    endcase
  end

endmodule

// File: rtl/neo_pattern_gen.sv
// Frame producer for the NeoPixel driver: one write per accepted ready_to_load, each frame sent REPEAT times.
// Stalls in place on ready_to_load/ready_to_send low; waits indefinitely for done_wait.
module neo_pattern_gen
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS = 5,
  parameter int LEVEL_W    = 8,
  parameter int REPEAT     = 4,
  localparam int IDX_W     = $clog2(NUM_PIXELS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [LEVEL_W-1:0] level_hi,
  input  logic [LEVEL_W-1:0] level_lo,
  input  logic               ready_to_load,
  input  logic               ready_to_send,
  input  logic               done_wait,
  output logic [IDX_W-1:0]   pixel_index,
  output logic [1:0]         color_index,
  output logic [LEVEL_W-1:0] color_level,
  output logic               load_color,
  output logic               send_it,
  output logic [7:0]         frame_count,
  output logic               busy
);

  localparam int SEND_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  state_t             state, state_nxt;
  mode_t              cap_mode;
  logic [LEVEL_W-1:0] cap_hi, cap_lo;
  logic [1:0]         ch_cnt;
  logic [IDX_W-1:0]   pix_cnt, phase;
  logic [SEND_W-1:0]  send_cnt;
  logic [IDX_W-1:0]   held_pix;
  logic [1:0]         held_ch;
  logic [LEVEL_W-1:0] held_lvl;
  logic [LEVEL_W-1:0] lut_level;
  logic               start, accept, write_last, send_done, send_last;

  assign accept     = (state == LOAD) && ready_to_load;
  assign write_last = (ch_cnt == CH_B) && (pix_cnt == IDX_W'(NUM_PIXELS - 1));
  assign send_done  = (state == SEND_WAIT) && done_wait;
  assign send_last  = (send_cnt == SEND_W'(REPEAT - 1));
  assign busy       = (state != IDLE);

  neo_counter #(.W(2), .MAX(3)) u_ch_cnt (
    .clock (clock), .reset (reset), .clear (start),
    .inc   (accept), .count (ch_cnt)
  );

  neo_counter #(.W(IDX_W), .MAX(NUM_PIXELS)) u_pix_cnt (
    .clock (clock), .reset (reset), .clear (start),
    .inc   (accept && (ch_cnt == CH_B)), .count (pix_cnt)
  );

  neo_counter #(.W(SEND_W), .MAX(REPEAT)) u_send_cnt (
    .clock (clock), .reset (reset), .clear (send_done && send_last),
    .inc   (send_done && !send_last), .count (send_cnt)
  );

  neo_counter #(.W(IDX_W), .MAX(NUM_PIXELS)) u_phase_cnt (
    .clock (clock), .reset (reset), .clear (1'b0),
    .inc   (send_done && send_last), .count (phase)
  );

  neo_counter #(.W(8), .MAX(256)) u_frame_cnt (
    .clock (clock), .reset (reset), .clear (1'b0),
    .inc   (send_done), .count (frame_count)
  );

  neo_pattern_lut #(.IDX_W(IDX_W), .LEVEL_W(LEVEL_W)) u_lut (
    .mode     (cap_mode),
    .p        (pix_cnt),
    .c        (ch_cnt),
    .ph       (phase),
    .level_hi (cap_hi),
    .level_lo (cap_lo),
    .level    (lut_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_mode <= SOLID;
      cap_hi   <= '0;
      cap_lo   <= '0;
    end else if (start) begin
      cap_mode <= mode_t'(mode);
      cap_hi   <= level_hi;
      cap_lo   <= level_lo;
    end
  end

  // Last accepted write, presented while the driver stalls the load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_pix <= '0;
      held_ch  <= '0;
      held_lvl <= '0;
    end else if (start) begin
      held_pix <= '0;
      held_ch  <= '0;
      held_lvl <= '0;
    end else if (accept) begin
      held_pix <= pix_cnt;
      held_ch  <= ch_cnt;
      held_lvl <= lut_level;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    load_color  = 1'b0;
    send_it     = 1'b0;
    pixel_index = '0;
    color_index = '0;
    color_level = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        load_color = ready_to_load;
        if (ready_to_load) begin
          pixel_index = pix_cnt;
          color_index = ch_cnt;
          color_level = lut_level;
          if (write_last) state_nxt = SEND_REQ;
        end else begin
          pixel_index = held_pix;
          color_index = held_ch;
          color_level = held_lvl;
        end
      end
      SEND_REQ: begin
        send_it = ready_to_send;
        if (ready_to_send) state_nxt = SEND_WAIT;
      end
      SEND_WAIT: begin
        if (done_wait) begin
          if (!send_last) begin
            state_nxt = SEND_REQ;
          end else if (enable) begin
            start     = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neo_pattern_gen.sv
// Directed bench for neo_pattern_gen (5 pixels, REPEAT=2): frame contents, stalls, repeats, wraps, reset.
module tb_neo_pattern_gen;

  localparam int NP = 5;
  localparam int LW = 8;
  localparam int RP = 2;
  localparam int IW = $clog2(NP);

  logic          clock = 1'b0;
  logic          reset, enable, ready_to_load, ready_to_send, done_wait;
  logic [1:0]    mode;
  logic [LW-1:0] level_hi, level_lo;
  logic [IW-1:0] pixel_index;
  logic [1:0]    color_index;
  logic [LW-1:0] color_level;
  logic          load_color, send_it, busy;
  logic [7:0]    frame_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [7:0]    exp_fc;
  logic [7:0]    exp_lv [15];

  neo_pattern_gen #(.NUM_PIXELS(NP), .LEVEL_W(LW), .REPEAT(RP)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .mode          (mode),
    .level_hi      (level_hi),
    .level_lo      (level_lo),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send),
    .done_wait     (done_wait),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_color    (load_color),
    .send_it       (send_it),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  // Walk writes w_from..w_to of a frame with ready_to_load high.
  task automatic frame(input int w_from, input int w_to, input int drop_at, input bit chk);
    for (int w = w_from; w <= w_to; w++) begin
      if (w == drop_at) enable = 1'b0;
      check("load_color", load_color, 1);
      check("pixel_index", pixel_index, w / 3);
      check("color_index", color_index, w % 3);
      if (chk) check("color_level", color_level, exp_lv[w]);
      nxt();
    end
    if (w_to == 14) begin
      check("load_after_frame", load_color, 0);
      check("pix_after_frame", pixel_index, 0);
      check("busy_after_frame", busy, 1);
    end
  endtask

  // REPEAT sends from SEND_REQ with ready_to_send high; done_wait arrives after three wait cycles.
  task automatic send();
    for (int k = 0; k < RP; k++) begin
      check("send_it", send_it, 1);
      check("load_in_send", load_color, 0);
      done_wait = 1'b1;
      nxt();
      done_wait = 1'b0;
      check("send_it_wait", send_it, 0);
      check("fc_coincident_done", frame_count, exp_fc);
      check("busy_wait", busy, 1);
      nxt();
      nxt();
      check("send_it_wait2", send_it, 0);
      done_wait = 1'b1;
      nxt();
      done_wait = 1'b0;
      exp_fc = exp_fc + 8'd1;
      check("frame_count", frame_count, exp_fc);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'b00; level_hi = '0; level_lo = '0;
    ready_to_load = 1'b0; ready_to_send = 1'b0; done_wait = 1'b0; exp_fc = 8'h00;
    nxt();
    check("rst_busy", busy, 0);
    check("rst_load", load_color, 0);
    check("rst_send", send_it, 0);
    check("rst_fc", frame_count, 0);
    check("rst_pix", pixel_index, 0);
    check("rst_ch", color_index, 0);
    check("rst_lvl", color_level, 0);

    // Frame A: SOLID phase 0, continuous writes
    mode = 2'b00; level_hi = 8'h18; level_lo = 8'h03;
    ready_to_load = 1'b1; enable = 1'b1; reset = 1'b0;
    nxt();
    exp_lv = '{8'h18, 0, 0, 8'h18, 0, 0, 8'h18, 0, 0, 8'h18, 0, 0, 8'h18, 0, 0};
    frame(0, 14, -1, 1'b1);
    check("sendreq_hold", send_it, 0);
    nxt();
    check("sendreq_hold2", send_it, 0);
    check("sendreq_busy", busy, 1);
    check("sendreq_load", load_color, 0);
    ready_to_send = 1'b1;
    #1;
    send();

    // Frame B: SOLID phase 1, stall after write 7
    exp_lv = '{0, 8'h18, 0, 0, 8'h18, 0, 0, 8'h18, 0, 0, 8'h18, 0, 0, 8'h18, 0};
    frame(0, 7, -1, 1'b1);
    ready_to_load = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      check("stall_load", load_color, 0);
      check("stall_pix", pixel_index, 2);
      check("stall_ch", color_index, 1);
      check("stall_lvl", color_level, 8'h18);
      nxt();
    end
    ready_to_load = 1'b1;
    #1;
    frame(8, 14, -1, 1'b1);
    mode = 2'b01;
    send();

    // Frame C: CHASE phase 2
    exp_lv = '{3, 0, 0, 3, 0, 0, 8'h18, 8'h18, 8'h18, 3, 0, 0, 3, 0, 0};
    frame(0, 14, -1, 1'b1);
    mode = 2'b10;
    send();

    // Frame D: ALTERNATE phase 3; inputs changed after capture must not leak in
    mode = 2'b11; level_hi = 8'h55;
    exp_lv = '{0, 0, 3, 0, 8'h18, 0, 0, 0, 3, 0, 8'h18, 0, 0, 0, 3};
    frame(0, 14, -1, 1'b1);
    send();

    // Frame E: OFF phase 4
    exp_lv = '{default: 0};
    frame(0, 14, -1, 1'b1);
    mode = 2'b01;
    send();

    // Frame F: CHASE, phase wrapped back to 0
    exp_lv = '{8'h55, 8'h55, 8'h55, 3, 0, 0, 3, 0, 0, 3, 0, 0, 3, 0, 0};
    frame(0, 14, -1, 1'b1);
    mode = 2'b11;
    send();

    // Bulk OFF frames up to 256 completed sends
    exp_lv = '{default: 0};
    for (int f = 6; f < 128; f++) begin
      frame(0, 14, -1, 1'b1);
      send();
    end
    check("fc_wrap", frame_count, 8'h00);

    // enable dropped mid-LOAD: frame still completes and sends twice
    frame(0, 14, 5, 1'b1);
    send();
    check("idle_busy", busy, 0);
    check("idle_load", load_color, 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      check("idle_stay_load", load_color, 0);
      check("idle_stay_send", send_it, 0);
      check("idle_stay_busy", busy, 0);
    end

    // Reset while in SEND_WAIT
    enable = 1'b1;
    nxt();
    frame(0, 14, -1, 1'b1);
    check("pre_rst_send", send_it, 1);
    nxt();
    check("pre_rst_wait", send_it, 0);
    check("pre_rst_fc", frame_count, 8'h02);
    enable = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_fc", frame_count, 0);
    check("arst_send", send_it, 0);
    check("arst_load", load_color, 0);
    nxt();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      done_wait = (i == 1);
      nxt();
      check("post_rst_send", send_it, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_fc", frame_count, 0);
    end
    done_wait = 1'b0;
    mode = 2'b00; level_hi = 8'h18; enable = 1'b1;
    nxt();
    check("restart_load", load_color, 1);
    check("restart_lvl0", color_level, 8'h18);
    nxt();
    check("restart_ch1", color_index, 1);
    check("restart_lvl1", color_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
